// File: rtl/tilemap_scroll_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tilemap_scroll_pipe
// Description : Four-stage background tilemap renderer. Turns each screen
//               row/col into one RGB444 pixel with per-frame X/Y scroll
//               and map wrap-around, per-tile palette select, a writable
//               tilemap RAM and a transparency flag.
//               Optional feature macro: TILEMAP_FLIP_EN (per-tile h/v flip).
//               The pattern, palette and colour memories are loaded by the
//               memory-initialisation flow from TILE_INIT, PAL_INIT and
//               COLOR_INIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tilemap_scroll_pipe #(
    parameter int MAP_COLS_LOG2 = 5,
    parameter int MAP_ROWS_LOG2 = 5,
    parameter int TILE_LOG2     = 3,
    parameter int TILE_IDX_W    = 8,
    parameter int PAL_SEL_W     = 5,
    parameter int DISP_W        = 256,
    parameter int DISP_H        = 224,
    parameter     TILE_INIT     = "tile_rom.mem",
    parameter     PAL_INIT      = "palette.mem",
    parameter     COLOR_INIT    = "colors.mem"
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    frame_start,
    input  logic [MAP_COLS_LOG2+TILE_LOG2-1:0]      scroll_x,
    input  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]      scroll_y,
    input  logic                                    in_valid,
    input  logic [8:0]                              row,
    input  logic [9:0]                              col,
    input  logic                                    tm_we,
    input  logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0]  tm_waddr,
    input  logic [PAL_SEL_W+TILE_IDX_W+1:0]         tm_wdata,
    output logic                                    out_valid,
    output logic [3:0]                              red,
    output logic [3:0]                              green,
    output logic [3:0]                              blue,
    output logic                                    transparent
);

    localparam int c_mx_w   = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int c_my_w   = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int c_tm_aw  = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int c_tm_dw  = PAL_SEL_W + TILE_IDX_W + 2;
    localparam int c_pnum_w = 2 * TILE_LOG2;
    localparam int c_pat_aw = TILE_IDX_W + c_pnum_w - 2;

    logic [c_tm_dw-1:0] r_tm_mem    [2**c_tm_aw];
    logic [7:0]         r_pat_mem   [2**c_pat_aw];
    logic [31:0]        r_pal_mem   [2**PAL_SEL_W];
    logic [7:0]         r_color_mem [16];

    logic [c_mx_w-1:0] r_active_sx;
    logic [c_my_w-1:0] r_active_sy;

    // Scroll offsets change only on the frame_start edge; the pixel in that
    // same cycle still sees the previous offsets.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_sx <= '0;
            r_active_sy <= '0;
        end else if (frame_start) begin
            r_active_sx <= scroll_x;
            r_active_sy <= scroll_y;
        end
    end

    // Map coordinates wrap by plain truncation to the map size.
    logic [c_mx_w-1:0] w_col_t, w_mx;
    logic [c_my_w-1:0] w_row_t, w_my;
    logic [c_tm_aw-1:0] w_tm_raddr;
    logic              w_in_win;

    assign w_col_t    = c_mx_w'(col);
    assign w_row_t    = c_my_w'(row);
    assign w_mx       = w_col_t + r_active_sx;
    assign w_my       = w_row_t + r_active_sy;
    assign w_tm_raddr = {w_my[c_my_w-1 -: MAP_ROWS_LOG2], w_mx[c_mx_w-1 -: MAP_COLS_LOG2]};
    assign w_in_win   = (col < 10'(DISP_W)) && (row < 9'(DISP_H));

    // Tilemap write port; the read below samples pre-write contents.
    always_ff @(posedge clk) begin
        if (tm_we) begin
            r_tm_mem[tm_waddr] <= tm_wdata;
        end
    end

    // S1: tilemap read plus in-tile offsets.
    logic [TILE_IDX_W-1:0] r_s1_tile;
    logic [PAL_SEL_W-1:0]  r_s1_pal;
    logic [TILE_LOG2-1:0]  r_s1_xoff, r_s1_yoff;
    logic                  r_s1_vld, r_s1_win;
`ifdef TILEMAP_FLIP_EN
    logic                  r_s1_hflip, r_s1_vflip;
`endif

    always_ff @(posedge clk) begin
        r_s1_tile <= r_tm_mem[w_tm_raddr][TILE_IDX_W-1:0];
        r_s1_pal  <= r_tm_mem[w_tm_raddr][TILE_IDX_W +: PAL_SEL_W];
`ifdef TILEMAP_FLIP_EN
        r_s1_hflip <= r_tm_mem[w_tm_raddr][c_tm_dw-2];
        r_s1_vflip <= r_tm_mem[w_tm_raddr][c_tm_dw-1];
`endif
        r_s1_xoff <= w_mx[TILE_LOG2-1:0];
        r_s1_yoff <= w_my[TILE_LOG2-1:0];
        r_s1_win  <= w_in_win;
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= in_valid;
        end
    end

    // Flip resolves on the S1 outputs so the tilemap read stays a plain
    // registered read; mirroring an offset is its bitwise complement.
    logic [TILE_LOG2-1:0] w_xoff, w_yoff;
    always_comb begin
        w_xoff = r_s1_xoff;
        w_yoff = r_s1_yoff;
`ifdef TILEMAP_FLIP_EN
        if (r_s1_hflip) w_xoff = ~r_s1_xoff;
        if (r_s1_vflip) w_yoff = ~r_s1_yoff;
`endif
    end

    logic [c_pnum_w-1:0] w_pnum;
    logic [c_pat_aw-1:0] w_pat_addr;
    assign w_pnum     = {w_yoff, w_xoff};
    assign w_pat_addr = {r_s1_tile, w_pnum[c_pnum_w-1:2]};

    // S2: pattern byte read (four 2-bit pixels per byte).
    logic [7:0]           r_s2_byte;
    logic [1:0]           r_s2_sub;
    logic [PAL_SEL_W-1:0] r_s2_pal;
    logic                 r_s2_vld, r_s2_win;

    always_ff @(posedge clk) begin
        r_s2_byte <= r_pat_mem[w_pat_addr];
        r_s2_sub  <= w_pnum[1:0];
        r_s2_pal  <= r_s1_pal;
        r_s2_win  <= r_s1_win;
        if (rst) begin
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
        end
    end

    // Pixel 0 of a pattern byte sits in the top two bits.
    logic [1:0] w_pix;
    always_comb begin
        case (r_s2_sub)
            2'd0:    w_pix = r_s2_byte[7:6];
            2'd1:    w_pix = r_s2_byte[5:4];
            2'd2:    w_pix = r_s2_byte[3:2];
            default: w_pix = r_s2_byte[1:0];
        endcase
    end

    // S3: pixel decode and palette read; only the low nibble of each palette
    // byte addresses the 16-entry colour table, so only those are kept.
    logic [1:0]  r_s3_pix;
    logic [15:0] r_s3_nibs;
    logic        r_s3_vld, r_s3_win;

    always_ff @(posedge clk) begin
        r_s3_pix  <= w_pix;
        r_s3_nibs <= {r_pal_mem[r_s2_pal][27:24], r_pal_mem[r_s2_pal][19:16],
                      r_pal_mem[r_s2_pal][11:8],  r_pal_mem[r_s2_pal][3:0]};
        r_s3_win  <= r_s2_win;
        if (rst) begin
            r_s3_vld <= 1'b0;
        end else begin
            r_s3_vld <= r_s2_vld;
        end
    end

    logic [3:0] w_cidx;
    logic [7:0] w_color;
    always_comb begin
        case (r_s3_pix)
            2'd0:    w_cidx = r_s3_nibs[15:12];
            2'd1:    w_cidx = r_s3_nibs[11:8];
            2'd2:    w_cidx = r_s3_nibs[7:4];
            default: w_cidx = r_s3_nibs[3:0];
        endcase
    end
    assign w_color = r_color_mem[w_cidx];

    // S4: colour-table read and BGR233 -> RGB444 expansion; colour outputs
    // hold through bubbles and are blanked outside the active window.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
            transparent <= 1'b0;
        end else begin
            out_valid <= r_s3_vld;
            if (r_s3_vld) begin
                if (r_s3_win) begin
                    red         <= {w_color[2:0], w_color[2]};
                    green       <= {w_color[5:3], w_color[5]};
                    blue        <= {w_color[7:6], w_color[7:6]};
                    transparent <= (r_s3_pix == 2'd0);
                end else begin
                    red         <= 4'h0;
                    green       <= 4'h0;
                    blue        <= 4'h0;
                    transparent <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
